// File: rtl/decoder1024_pkg.sv
// Shared definitions for the decoder1024 front end.
// Contents: loader FSM state enum, default SIPO length/word width, clog2 helper.
package decoder1024_pkg;

  localparam int unsigned SIZE_DEF = 1024;
  localparam int unsigned W_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sipo_frame_loader_if.sv
// Word handshake between a frame source and sipo_frame_loader.
// Signals: word_data (W), word_valid (source -> loader), word_ready (loader -> source).
interface sipo_frame_loader_if #(
  parameter int unsigned W = 16
) ();

  logic [W-1:0] word_data;
  logic         word_valid;
  logic         word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);

endinterface

// File: rtl/piso_word.sv
// W-bit load/shift register feeding the SIPO serial input, MSB first.
// Ports: clk, rnot (sync active-low reset), i_load (load i_data, wins over shift),
//        i_shift (shift left by one), i_data (W), o_msb (current bit W-1).
module piso_word #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rnot,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_shreg;

  // Load a fresh word or move the next bit into the MSB position.
  always_ff @(posedge clk) begin
    if (!rnot) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
    end else if (i_shift) begin
      r_shreg <= {r_shreg[W-2:0], 1'b0};
    end
  end

  assign o_msb = r_shreg[W-1];

endmodule

// File: rtl/sipo_frame_loader.sv
// Feeds a SIZE-bit SIPO: clears it, then serializes SIZE/W handshaked words
// MSB first so word 0 ends up in out[SIZE-1 -: W].
// Ports: clk, rnot (sync active-low reset), start, abort, word_if (slave word
//        handshake), sipo_clear, sipo_en, sipo_in, busy, frame_done, frame_valid.
module sipo_frame_loader
  import decoder1024_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEF,
  parameter int unsigned W    = W_DEF
) (
  input  logic                clk,
  input  logic                rnot,
  input  logic                start,
  input  logic                abort,
  sipo_frame_loader_if.slave  word_if,
  output logic                sipo_clear,
  output logic                sipo_en,
  output logic                sipo_in,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_valid
);

  localparam int unsigned NWORDS = SIZE / W;
  localparam int unsigned BW     = clog2(W);
  localparam int unsigned WCW    = (NWORDS > 1) ? clog2(NWORDS) : 1;

  state_e         r_state, w_state_nxt;
  logic [BW-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [WCW-1:0] r_word_cnt, w_word_cnt_nxt;
  logic           r_sipo_clear, r_sipo_en, r_busy, r_frame_done, r_frame_valid;
  logic           w_frame_valid_nxt;
  logic           w_last_bit, w_last_word, w_ready, w_accept;
  logic           w_load, w_shift, w_msb;

  assign w_last_bit  = (r_bit_cnt == BW'(W - 1));
  assign w_last_word = (r_word_cnt == WCW'(NWORDS - 1));

  // Ready in LOAD, and in the last bit slot of a non-final word for back-to-back reload.
  assign w_ready  = (r_state == ST_LOAD) ||
                    ((r_state == ST_SHIFT) && w_last_bit && !w_last_word);
  assign w_accept = word_if.word_valid && w_ready;

  assign word_if.word_ready = w_ready;

  piso_word #(.W(W)) u_piso (
    .clk     (clk),
    .rnot    (rnot),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (word_if.word_data),
    .o_msb   (w_msb)
  );

  // State, counters and registered outputs; outputs decode the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rnot) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_word_cnt    <= '0;
      r_sipo_clear  <= 1'b0;
      r_sipo_en     <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_word_cnt    <= w_word_cnt_nxt;
      r_sipo_clear  <= (w_state_nxt == ST_CLEAR);
      r_sipo_en     <= (w_state_nxt == ST_SHIFT);
      r_busy        <= (w_state_nxt == ST_CLEAR) || (w_state_nxt == ST_LOAD) ||
                       (w_state_nxt == ST_SHIFT);
      r_frame_done  <= (w_state_nxt == ST_DONE);
      r_frame_valid <= w_frame_valid_nxt;
    end
  end

  // Next-state, counter and shift-register control.
  always_comb begin
    w_state_nxt       = r_state;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_word_cnt_nxt    = r_word_cnt;
    w_frame_valid_nxt = r_frame_valid;
    w_load            = 1'b0;
    w_shift           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt       = ST_CLEAR;
          w_frame_valid_nxt = 1'b0;
        end
      end
      ST_CLEAR: begin
        w_word_cnt_nxt = '0;
        w_state_nxt    = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_accept) begin
          w_load        = 1'b1;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!w_last_bit) begin
          w_shift       = 1'b1;
          w_bit_cnt_nxt = r_bit_cnt + BW'(1);
        end else if (!w_last_word) begin
          w_word_cnt_nxt = r_word_cnt + WCW'(1);
          if (w_accept) begin
            w_load        = 1'b1;
            w_bit_cnt_nxt = '0;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end else begin
          w_state_nxt       = ST_DONE;
          w_frame_valid_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt       = ST_CLEAR;
          w_frame_valid_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Abort beats start and any word handshake in the same cycle.
    if (abort) begin
      w_state_nxt       = ST_IDLE;
      w_load            = 1'b0;
      w_shift           = 1'b0;
      w_frame_valid_nxt = 1'b0;
    end
  end

  assign sipo_clear  = r_sipo_clear;
  assign sipo_en     = r_sipo_en;
  assign sipo_in     = w_msb;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_sipo_frame_loader.sv
// Bench for sipo_frame_loader: SIPO model plus a word scoreboard checked on frame_done,
// followed by a small 32/8 instance.
module tb_sipo_frame_loader;

  localparam int unsigned SIZE  = 1024;
  localparam int unsigned W     = 16;
  localparam int unsigned NW    = SIZE / W;
  localparam int unsigned SSIZE = 32;
  localparam int unsigned SW    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rnot, start, abort;
  logic sipo_clear, sipo_en, sipo_in, busy, frame_done, frame_valid;
  logic start_s, abort_s;
  logic sipo_clear_s, sipo_en_s, sipo_in_s, busy_s, frame_done_s, frame_valid_s;

  sipo_frame_loader_if #(.W(W))  bus ();
  sipo_frame_loader_if #(.W(SW)) bus_s ();

  sipo_frame_loader #(.SIZE(SIZE), .W(W)) dut (
    .clk(clk), .rnot(rnot), .start(start), .abort(abort), .word_if(bus),
    .sipo_clear(sipo_clear), .sipo_en(sipo_en), .sipo_in(sipo_in), .busy(busy),
    .frame_done(frame_done), .frame_valid(frame_valid));

  sipo_frame_loader #(.SIZE(SSIZE), .W(SW)) dut_s (
    .clk(clk), .rnot(rnot), .start(start_s), .abort(abort_s), .word_if(bus_s),
    .sipo_clear(sipo_clear_s), .sipo_en(sipo_en_s), .sipo_in(sipo_in_s), .busy(busy_s),
    .frame_done(frame_done_s), .frame_valid(frame_valid_s));

  // Downstream SIPO models: clear, or shift toward the MSB.
  logic [SIZE-1:0]  sipo;
  logic [SSIZE-1:0] sipo_s;
  always @(posedge clk) begin
    if (sipo_clear) sipo <= '0;
    else if (sipo_en) sipo <= {sipo[SIZE-2:0], sipo_in};
    if (sipo_clear_s) sipo_s <= '0;
    else if (sipo_en_s) sipo_s <= {sipo_s[SSIZE-2:0], sipo_in_s};
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] frame_words[NW];
  int idx, en_cnt, clr_cnt, done_cnt, hold_cnt, done_cyc, lat, ended;
  int opt_stall_word, opt_stall_len, opt_abort_at, opt_start_at, opt_glitch_at, opt_reset_at;
  bit opt_chain, opt_skip_start;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pop one frame's worth of expected words and compare against the SIPO image.
  task automatic check_frame();
    logic [W-1:0] e;
    chk("fv_at_done", 64'(frame_valid), 64'd1);
    chk("sb_depth", 64'(exp_q.size()), 64'(NW));
    for (int k = 0; k < int'(NW); k++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("word%0d", k), 64'(sipo[SIZE-1-k*W -: W]), 64'(e));
      end
    end
  endtask

  // Sample outputs at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (bus.word_valid && bus.word_ready && !abort && rnot) begin
      exp_q.push_back(bus.word_data);
      idx++;
    end
    if (sipo_en) en_cnt++;
    if (sipo_clear) clr_cnt++;
    if (busy && !sipo_en && !sipo_clear) hold_cnt++;
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
      check_frame();
    end
    if (abort || !rnot) exp_q.delete();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_opts();
    opt_stall_word = -1; opt_stall_len = 0; opt_abort_at = -1; opt_start_at = -1;
    opt_glitch_at = -1; opt_reset_at = -1; opt_chain = 0; opt_skip_start = 0;
  endtask

  // Drive one frame from frame_words; ended = 0 done, 1 aborted, 2 reset.
  task automatic run_frame();
    int t0;
    int stall_left;
    bit glitched;
    idx = 0; en_cnt = 0; clr_cnt = 0; done_cnt = 0; hold_cnt = 0;
    done_cyc = -1; ended = 0; stall_left = opt_stall_len; glitched = 0;
    if (!opt_skip_start) begin
      t0 = cyc; start = 1'b1; tick(); start = 1'b0;
    end else begin
      t0 = cyc - 1;
    end
    for (int g = 0; g < 3000; g++) begin
      if (frame_done) break;
      bus.word_valid = (idx < int'(NW));
      if (idx < int'(NW)) bus.word_data = frame_words[idx];
      if (idx == opt_stall_word && stall_left > 0 && bus.word_ready) begin
        bus.word_valid = 1'b0;
        stall_left--;
      end
      abort = sipo_en && (en_cnt == opt_abort_at);
      start = sipo_en && (en_cnt == opt_start_at);
      if (sipo_en && en_cnt == opt_glitch_at && !glitched) begin
        rnot = 1'b0; #2; rnot = 1'b1; glitched = 1;
      end
      if (sipo_en && en_cnt == opt_reset_at) begin
        rnot = 1'b0; tick(); rnot = 1'b1; ended = 2;
        break;
      end
      tick();
      start = 1'b0;
      if (abort) begin
        abort = 1'b0; ended = 1;
        break;
      end
    end
    bus.word_valid = 1'b0;
    if (ended == 0) begin
      chk("frame_done_timeout", 64'(frame_done), 64'd1);
      start = opt_chain;
      tick();
      start = 1'b0;
      lat = done_cyc - t0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clear"}, 64'(sipo_clear), 64'd0);
    chk({tag, "_en"}, 64'(sipo_en), 64'd0);
    chk({tag, "_in"}, 64'(sipo_in), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(frame_done), 64'd0);
    chk({tag, "_fv"}, 64'(frame_valid), 64'd0);
    chk({tag, "_ready"}, 64'(bus.word_ready), 64'd0);
  endtask

  initial begin
    logic [SW-1:0] ws[4];
    int t0, si;
    bit acc;
    rnot = 1'b0; start = 1'b0; abort = 1'b0; start_s = 1'b0; abort_s = 1'b0;
    bus.word_valid = 1'b0; bus.word_data = '0;
    bus_s.word_valid = 1'b0; bus_s.word_data = '0;
    set_opts();
    @(posedge clk); #1;
    repeat (3) tick();
    rnot = 1'b1;
    chk_all_zero("reset");

    // Single set bit lands in out[SIZE-1].
    for (int k = 0; k < int'(NW); k++) frame_words[k] = (k == 0) ? 16'h8000 : 16'h0000;
    run_frame();
    chk("t1_latency", 64'(lat), 64'd1027);
    chk("t1_msb", 64'(sipo[SIZE-1]), 64'd1);
    chk("t1_ones", 64'($countones(sipo)), 64'd1);
    chk("t1_en_cycles", 64'(en_cnt), 64'd1024);
    chk("t1_clears", 64'(clr_cnt), 64'd1);
    chk("t1_holds", 64'(hold_cnt), 64'd1);
    chk("t1_done_pulses", 64'(done_cnt), 64'd1);
    chk("t1_idle_fv", 64'(frame_valid), 64'd1);
    chk("t1_idle_busy", 64'(busy), 64'd0);

    // Three-cycle valid stall in front of word 10.
    for (int k = 0; k < int'(NW); k++) frame_words[k] = 16'(k + 1);
    opt_stall_word = 10; opt_stall_len = 3;
    run_frame();
    chk("t2_latency", 64'(lat), 64'd1030);
    chk("t2_holds", 64'(hold_cnt), 64'd4);
    chk("t2_en_cycles", 64'(en_cnt), 64'd1024);
    chk("t2_low_word", 64'(sipo[15:0]), 64'h0040);
    chk("t2_high_word", 64'(sipo[SIZE-1 -: 16]), 64'h0001);

    // Abort at word 20 bit 5, then a clean restart.
    set_opts();
    for (int k = 0; k < int'(NW); k++) frame_words[k] = 16'($urandom);
    opt_abort_at = 20 * 16 + 5;
    run_frame();
    chk("t3_aborted", 64'(ended), 64'd1);
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_en", 64'(sipo_en), 64'd0);
    chk("t3_fv", 64'(frame_valid), 64'd0);
    chk("t3_ready", 64'(bus.word_ready), 64'd0);
    set_opts();
    run_frame();
    chk("t3_restart_clears", 64'(clr_cnt), 64'd1);
    chk("t3_restart_latency", 64'(lat), 64'd1027);

    // Start during SHIFT ignored; start in DONE goes straight to CLEAR.
    for (int k = 0; k < int'(NW); k++) frame_words[k] = 16'($urandom);
    opt_start_at = 100; opt_chain = 1;
    run_frame();
    chk("t4_done_pulses", 64'(done_cnt), 64'd1);
    chk("t4_latency", 64'(lat), 64'd1027);
    chk("t4_chain_clear", 64'(sipo_clear), 64'd1);
    chk("t4_chain_busy", 64'(busy), 64'd1);
    chk("t4_chain_fv", 64'(frame_valid), 64'd0);
    set_opts();
    opt_skip_start = 1;
    for (int k = 0; k < int'(NW); k++) frame_words[k] = 16'($urandom);
    run_frame();
    chk("t4b_latency", 64'(lat), 64'd1027);

    // Glitch on rnot between edges is ignored; a sampled low resets everything.
    set_opts();
    opt_glitch_at = 50; opt_reset_at = 200;
    run_frame();
    chk("t5_reset_taken", 64'(ended), 64'd2);
    chk_all_zero("t5");

    // 32-bit frame of 8-bit words.
    ws[0] = 8'hA5; ws[1] = 8'h3C; ws[2] = 8'hFF; ws[3] = 8'h01;
    t0 = cyc; start_s = 1'b1; tick(); start_s = 1'b0; si = 0;
    for (int g = 0; g < 100; g++) begin
      if (frame_done_s) break;
      bus_s.word_valid = (si < 4);
      if (si < 4) bus_s.word_data = ws[si];
      acc = bus_s.word_valid && bus_s.word_ready;
      tick();
      if (acc) si++;
    end
    bus_s.word_valid = 1'b0;
    chk("t6_done", 64'(frame_done_s), 64'd1);
    chk("t6_latency", 64'(cyc - t0), 64'd35);
    chk("t6_image", 64'(sipo_s), 64'hA53CFF01);
    chk("t6_fv", 64'(frame_valid_s), 64'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sipo_frame_loader.md
Name: sipo_frame_loader

Overview:
Upstream feeder for the 1024-bit SIPO shift register in the decoder1024 datapath.
- Accepts a frame as SIZE/W parallel words over a valid/ready handshake.
- Clears the SIPO, then serializes each word MSB-first onto the SIPO's serial input with a matching shift-enable.
- Flags frame completion, at which point the SIPO parallel output holds the frame image for the downstream decoder.

Parameters:
SIZE, 1024, SIPO length in bits; frame length.
W, 16, input word width; SIZE mod W must be 0 and W ≥ 2.
NWORDS, SIZE/W, words per frame (derived, not overridable).

Ports:
clk  input  1  single system clock; all flops rising-edge.
rnot  input  1  synchronous active-low reset.
start  input  1  begin a new frame; sampled only in IDLE or DONE.
abort  input  1  cancel the frame in progress; returns to IDLE.
word_data  input  W  next frame word.
word_valid  input  1  word_data is valid.
word_ready  output  1  loader accepts word_data this cycle.
sipo_clear  output  1  drives the SIPO clear input; active high.
sipo_en  output  1  drives the SIPO enable input (shift when 1, hold when 0).
sipo_in  output  1  drives the SIPO serial input.
busy  output  1  frame in progress (CLEAR, LOAD or SHIFT).
frame_done  output  1  one-cycle pulse after the final bit is shifted.
frame_valid  output  1  level; SIPO holds a complete frame.

Behaviour:
- Reset (rnot=0 at a clk edge): state=IDLE, counters=0, shift register=0. All outputs 0.
- All outputs except word_ready are driven directly from flops.
- word_ready is combinational from state and counters only. It never depends on word_valid.
- Bit order: the first bit shifted lands in SIPO out[SIZE-1].
  - Word k maps to out[SIZE-1-k*W : SIZE-k*W-W], MSB first.
  - So word 0 = out[1023:1008] and word 63 = out[15:0] (defaults).
- IDLE:
  - start=1 -> CLEAR; frame_valid <= 0.
  - sipo_en=0, busy=0.
- CLEAR:
  - sipo_clear=1 for exactly one cycle; word_cnt <= 0.
  - Next -> LOAD.
- LOAD:
  - word_ready=1.
  - On word_valid & word_ready: shreg <= word_data, bit_cnt <= 0 -> SHIFT.
  - Otherwise stay in LOAD (sipo_en=0, SIPO holds).
- SHIFT:
  - sipo_en=1, sipo_in=shreg[W-1]; shreg shifts left by 1 each cycle; bit_cnt increments.
  - On bit_cnt==W-1 with word_cnt<NWORDS-1:
    - word_ready=1 (back-to-back accept).
    - If a word is accepted: reload shreg, word_cnt+1, bit_cnt <= 0, stay in SHIFT.
    - Otherwise: word_cnt+1 -> LOAD.
  - On bit_cnt==W-1 with word_cnt==NWORDS-1 -> DONE.
- DONE:
  - frame_done=1 for exactly one cycle (the cycle after the final shift); frame_valid=1 held.
  - sipo_en=0, busy=0.
  - Next -> IDLE. frame_valid stays 1 until the next start.
  - start is also honoured in DONE (-> CLEAR).
- start while busy: ignored.
- abort:
  - Any state -> IDLE next cycle; sipo_en=0 and frame_valid=0.
  - SIPO contents are partial and undefined to the consumer.
  - abort takes priority over start and over a word handshake in the same cycle.
- Minimum frame latency, start to frame_done: 1 (IDLE) + 1 (CLEAR) + 1 (first LOAD) + SIZE (SHIFT) cycles = SIZE+3.
  - This assumes word_valid is held high throughout.
- Each word_valid stall inserts exactly one hold cycle per missed back-to-back slot.
- Counters:
  - bit_cnt is clog2(W) bits.
  - word_cnt is clog2(NWORDS) bits; it never wraps within a frame.
- Mid-frame reset: same as the reset values above. SIPO is not cleared by this block until the next CLEAR.

Decomposition:
- Shared package decoder1024_pkg holds:
  - the state enum (IDLE, CLEAR, LOAD, SHIFT, DONE);
  - SIZE_DEF=1024 and W_DEF=16;
  - a clog2 helper.
- Natural sub-module: piso_word, a W-bit load/shift register with load, shift and msb output. The FSM and counters stay in the top.

Test Plan:
1. Reset, then start with 64 words 0x8000,0x0000,... held valid -> frame_done at cycle start+1027; SIPO out[1023]=1 and all other bits 0; frame_valid=1.
2. Words 0x0001..0x0040 with word_valid deasserted 3 cycles before word 10 -> exactly 3 extra hold cycles with sipo_en=0; final out[15:0]=0x0040 and out[1023:1008]=0x0001.
3. abort asserted at word 20, bit 5 -> next cycle IDLE, sipo_en=0, busy=0, frame_valid=0; later start performs CLEAR (sipo_clear pulse) and a full reload.
4. start pulsed during SHIFT -> ignored; a single frame_done pulse; start in the DONE cycle -> CLEAR on the next cycle.
5. rnot=0 for 1 cycle mid-SHIFT -> all outputs 0 next cycle, state IDLE; async glitch on rnot between edges -> no effect.
6. SIZE=32, W=8, words 0xA5,0x3C,0xFF,0x01 -> SIPO out=0xA53CFF01 and frame_done at start+35.
